serial_alu_seq: RTL and testbench

//  Bit-serial N-bit ALU sequencer. Latches two WIDTH-bit operands and a 3-bit opcode
//  on a start handshake, then steps one internal 1-bit ALU slice (with its own carry

---
 rtl/serial_alu_seq.sv | 137 +++++++++++++
 tb/tb_serial_alu_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: latches operands on start, then steps a 1-bit ALU slice
// LSB-first for WIDTH cycles and publishes result/carry/zero with a one-cycle done.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one bit-step per clock, LSB first
    // S_DONE | result valid (done pulse); start here chains the next op
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_INC  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  sr_next;
    logic [2:0]        op_reg;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic              accept;
    logic              last_step;
    logic              a_bit;
    logic              b_bit;
    logic              sum_bit;
    logic              carry_next;
    logic              slice_bit;
    logic              arith;

    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_step = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (last_step) next_state = S_DONE;
            S_DONE:  next_state = start ? S_RUN : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // 1-bit ALU slice; SUB is a + ~b + 1, INC is a + 0 + 1
    always_comb begin
        a_bit = a_sh[0];
        case (op_reg)
            OP_SUB:  b_bit = ~b_sh[0];
            OP_INC:  b_bit = 1'b0;
            default: b_bit = b_sh[0];
        endcase
        sum_bit    = a_bit ^ b_bit ^ carry;
        carry_next = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
        arith      = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_INC);
        case (op_reg)
            OP_AND:  slice_bit = a_bit & b_sh[0];
            OP_OR:   slice_bit = a_bit | b_sh[0];
            OP_XOR:  slice_bit = a_bit ^ b_sh[0];
            OP_NOT:  slice_bit = ~a_bit;
            OP_PASS: slice_bit = b_sh[0];
            default: slice_bit = sum_bit;
        endcase
        sr_next = {slice_bit, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sr        <= '0;
            op_reg    <= OP_ADD;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sr     <= '0;
            op_reg <= opcode;
            cnt    <= '0;
            carry  <= (opcode == OP_SUB) || (opcode == OP_INC);
        end else if (state == S_RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            sr   <= sr_next;
            cnt  <= cnt + 1'b1;
            if (arith) begin
                carry <= carry_next;
            end
            // Outputs only change on entry to DONE so partial results stay hidden
            if (last_step) begin
                result    <= sr_next;
                carry_out <= arith ? carry_next : 1'b0;
                zero      <= (sr_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq (WIDTH=8): latency, arithmetic/logic results,
// ignored mid-run start, reset abort and back-to-back chaining.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;

    int checks = 0;
    int errors = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Issues one op and waits for done; lat counts negedges from start to done (9 expected).
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [W-1:0] r, output logic c, output logic z,
                          output int lat, output int busy_cnt, output int both_hi);
        lat = -1;
        busy_cnt = 0;
        both_hi = 0;
        r = '0; c = 1'b0; z = 1'b0;
        @(negedge clk);
        opcode = op; a = av; b = bv; start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (busy && done) both_hi++;
            if (done) begin
                lat = n;
                r = result; c = carry_out; z = zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opcode = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, result, carry_out, zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h c=%b z=%b, want all 0",
                     busy, done, result, carry_out, zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_wrap();
        logic [W-1:0] r; logic c, z; int lat, bc, bh;
        run_op(3'b000, 8'hFF, 8'h01, r, c, z, lat, bc, bh);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL add_latency: got %0d want 9", lat); end
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL add_busy_cycles: got %0d want 8", bc); end
        checks++;
        if ({r, c, z} !== {8'h00, 1'b1, 1'b1}) begin
            errors++; $display("FAIL add_ff_01: got r=%h c=%b z=%b want r=00 c=1 z=1", r, c, z);
        end
        checks++;
        if (bh !== 0) begin errors++; $display("FAIL busy_done_overlap: got %0d want 0", bh); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done); end
    endtask

    task automatic test_sub();
        logic [W-1:0] r; logic c, z; int lat, bc, bh;
        run_op(3'b001, 8'h05, 8'h07, r, c, z, lat, bc, bh);
        checks++;
        if ({r, c, z} !== {8'hFE, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_05_07: got r=%h c=%b z=%b want r=fe c=0 z=0", r, c, z);
        end
        run_op(3'b001, 8'h07, 8'h05, r, c, z, lat, bc, bh);
        checks++;
        if ({r, c, z} !== {8'h02, 1'b1, 1'b0}) begin
            errors++; $display("FAIL sub_07_05: got r=%h c=%b z=%b want r=02 c=1 z=0", r, c, z);
        end
        run_op(3'b001, 8'h33, 8'h33, r, c, z, lat, bc, bh);
        checks++;
        if ({r, c, z} !== {8'h00, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sub_33_33: got r=%h c=%b z=%b want r=00 c=1 z=1", r, c, z);
        end
    endtask

    task automatic test_logic_ops();
        logic [2:0]   ops  [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b110};
        logic [W-1:0] expr [6] = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'h3C, 8'hF1};
        logic [W-1:0] r; logic c, z; int lat, bc, bh;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], 8'hF0, 8'h3C, r, c, z, lat, bc, bh);
            checks++;
            if ({r, c, z} !== {expr[i], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL logic_op_%0d: got r=%h c=%b z=%b want r=%h c=0 z=0",
                         ops[i], r, c, z, expr[i]);
            end
        end
        run_op(3'b110, 8'hFF, 8'h00, r, c, z, lat, bc, bh);
        checks++;
        if ({r, c, z} !== {8'h00, 1'b1, 1'b1}) begin
            errors++; $display("FAIL inc_ff: got r=%h c=%b z=%b want r=00 c=1 z=1", r, c, z);
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        logic [W-1:0] r = '0;
        @(negedge clk);
        opcode = 3'b000; a = 8'h12; b = 8'h34; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 3) begin start = 1'b1; a = 8'hFF; end
            if (n == 4) start = 1'b0;
            if (done) begin dones++; r = result; end
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        checks++;
        if (r !== 8'h46) begin errors++; $display("FAIL ignore_result: got %h want 46", r); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        logic [W-1:0] r; logic c, z; int lat, bc, bh;
        @(negedge clk);
        opcode = 3'b000; a = 8'h10; b = 8'h20; start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, result} !== {1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL abort_state: got busy=%b done=%b result=%h want 0 0 00",
                               busy, done, result);
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        run_op(3'b000, 8'h01, 8'h01, r, c, z, lat, bc, bh);
        checks++;
        if ({r, c, z, lat} !== {8'h02, 1'b0, 1'b0, 32'sd9}) begin
            errors++; $display("FAIL post_abort_add: got r=%h c=%b z=%b lat=%0d want 02 0 0 9",
                               r, c, z, lat);
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        logic [W-1:0] r1 = '0, r2 = '0;
        logic c1 = 1'b0;
        @(negedge clk);
        opcode = 3'b001; a = 8'h07; b = 8'h05; start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin opcode = 3'b000; a = 8'h10; b = 8'h20; end
            if (n == 10) start = 1'b0;
            if (done && d1 < 0) begin d1 = n; r1 = result; c1 = carry_out; end
            else if (done && d2 < 0) begin d2 = n; r2 = result; end
        end
        checks++;
        if ({d1, d2} !== {32'sd9, 32'sd18}) begin
            errors++; $display("FAIL b2b_timing: got done at %0d,%0d want 9,18", d1, d2);
        end
        checks++;
        if ({r1, c1, r2} !== {8'h02, 1'b1, 8'h30}) begin
            errors++; $display("FAIL b2b_results: got %h/%b %h want 02/1 30", r1, c1, r2);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_logic_ops();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
